// File: rtl/iic_write_engine.sv
// ---------------------------------------------------------------------------
// iic_write_engine
//   Single-master I2C write engine. One accepted request produces
//   START, {dev_addr,W}, register address (1 or 2 bytes), data byte, STOP.
//   Each bit is split into four quarter periods: SDA changes in quarter 0,
//   SCL is high in quarters 1-2, ACK is sampled at the end of quarter 2.
//
// Parameters
//   CLK_FRE          system clock in MHz
//   IIC_FRE          SCL frequency in kHz
//   IIC_SLAVE_REG_EX 0 = 8-bit register address, 1 = 16-bit
//
// Ports
//   clk, rst_n   system clock, asynchronous active-low reset
//   slave_addr   device address in [7:1], bit 0 ignored
//   reg_addr     register address (8 or 16 bits)
//   send_data    data byte
//   send_en      write request, honoured only while idle
//   send_busy    transaction in progress
//   ack_err      last transaction saw a NACK
//   iic_scl      push-pull SCL
//   iic_sda      open-drain SDA (drives 0 or Z)
// ---------------------------------------------------------------------------
module iic_write_engine #(
  parameter int CLK_FRE          = 50,
  parameter int IIC_FRE          = 100,
  parameter int IIC_SLAVE_REG_EX = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [7:0]                      slave_addr,
  input  logic [8+8*IIC_SLAVE_REG_EX-1:0] reg_addr,
  input  logic [7:0]                      send_data,
  input  logic                            send_en,
  output logic                            send_busy,
  output logic                            ack_err,
  output logic                            iic_scl,
  inout  wire                             iic_sda
);

  localparam int Q  = CLK_FRE * 1000 / (IIC_FRE * 4);
  localparam int QW = (Q > 1) ? $clog2(Q) : 1;
  localparam int RW = 8 + 8 * IIC_SLAVE_REG_EX;
  localparam logic [1:0] LAST_BYTE = 2'(2 + IIC_SLAVE_REG_EX);

  typedef enum logic [2:0] {IDLE, START, SHIFT, ACK, STOP} state_t;

  state_t          state, state_n;
  logic [QW-1:0]   qcnt;
  logic            tick;
  logic [2:0]      qtr, qtr_n;
  logic [3:0]      bit_cnt, bit_n;
  logic [1:0]      byte_cnt, byte_n;
  logic            ack_err_n;
  logic            latch;
  logic [7:1]      sa_l;
  logic [RW-1:0]   ra_l;
  logic [7:0]      sd_l;
  logic [7:0]      byte_nx;
  logic            bit_val;
  logic            sda_oe;
  logic [1:0]      sda_sync;
  logic            sda_in;

  assign iic_sda = sda_oe ? 1'b0 : 1'bz;
  assign sda_in  = sda_sync[1];
  assign tick    = (state != IDLE) && (qcnt == QW'(Q - 1));

  // Byte order on the bus. With an 8-bit register address the high-byte
  // slot collapses onto the low byte and the data moves up one slot.
  function automatic logic [7:0] byte_sel(input logic [1:0] idx);
    case (idx)
      2'd0:    byte_sel = {sa_l, 1'b0};
      2'd1:    byte_sel = ra_l[RW-1 -: 8];
      2'd2:    byte_sel = (IIC_SLAVE_REG_EX != 0) ? ra_l[7:0] : sd_l;
      default: byte_sel = sd_l;
    endcase
  endfunction

  function automatic logic scl_of(input state_t s, input logic [2:0] q);
    case (s)
      START:      scl_of = (q < 3'd2);
      SHIFT, ACK: scl_of = (q == 3'd1) || (q == 3'd2);
      STOP:       scl_of = (q != 3'd0);
      default:    scl_of = 1'b1;
    endcase
  endfunction

  // STOP: SDA low while SCL rises (q1), released at q2, q2..q5 is bus-free.
  function automatic logic oe_of(input state_t s, input logic [2:0] q, input logic b);
    case (s)
      START:   oe_of = 1'b1;
      SHIFT:   oe_of = ~b;
      STOP:    oe_of = (q < 3'd2);
      default: oe_of = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_n   = state;
    qtr_n     = qtr;
    bit_n     = bit_cnt;
    byte_n    = byte_cnt;
    ack_err_n = ack_err;
    latch     = 1'b0;
    case (state)
      IDLE: begin
        if (send_en) begin
          state_n   = START;
          qtr_n     = 3'd0;
          bit_n     = 4'd0;
          byte_n    = 2'd0;
          ack_err_n = 1'b0;
          latch     = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (qtr == 3'd3) begin
            state_n = SHIFT;
            qtr_n   = 3'd0;
          end else begin
            qtr_n = qtr + 3'd1;
          end
        end
      end
      SHIFT: begin
        if (tick) begin
          if (qtr == 3'd3) begin
            qtr_n = 3'd0;
            if (bit_cnt == 4'd7) begin
              state_n = ACK;
              bit_n   = 4'd8;
            end else begin
              bit_n = bit_cnt + 4'd1;
            end
          end else begin
            qtr_n = qtr + 3'd1;
          end
        end
      end
      ACK: begin
        if (tick) begin
          if (qtr == 3'd2 && sda_in) ack_err_n = 1'b1;
          if (qtr == 3'd3) begin
            qtr_n = 3'd0;
            if (ack_err || byte_cnt == LAST_BYTE) begin
              state_n = STOP;
            end else begin
              state_n = SHIFT;
              bit_n   = 4'd0;
              byte_n  = byte_cnt + 2'd1;
            end
          end else begin
            qtr_n = qtr + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (qtr == 3'd5) begin
            state_n = IDLE;
            qtr_n   = 3'd0;
          end else begin
            qtr_n = qtr + 3'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so SCL/SDA are
  // glitch-free and line up with the state they belong to.
  always_comb begin
    byte_nx = byte_sel(byte_n);
    bit_val = byte_nx[~bit_n[2:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      qcnt      <= '0;
      qtr       <= 3'd0;
      bit_cnt   <= 4'd0;
      byte_cnt  <= 2'd0;
      ack_err   <= 1'b0;
      send_busy <= 1'b0;
      iic_scl   <= 1'b1;
      sda_oe    <= 1'b0;
      sda_sync  <= 2'b11;
      sa_l      <= '0;
      ra_l      <= '0;
      sd_l      <= '0;
    end else begin
      state     <= state_n;
      qcnt      <= (state == IDLE || tick) ? '0 : qcnt + 1'b1;
      qtr       <= qtr_n;
      bit_cnt   <= bit_n;
      byte_cnt  <= byte_n;
      ack_err   <= ack_err_n;
      send_busy <= (state_n != IDLE);
      iic_scl   <= scl_of(state_n, qtr_n);
      sda_oe    <= oe_of(state_n, qtr_n, bit_val);
      sda_sync  <= {sda_sync[0], iic_sda};
      if (latch) begin
        sa_l <= slave_addr[7:1];
        ra_l <= reg_addr;
        sd_l <= send_data;
      end
    end
  end

endmodule
